// File: rtl/ysyx_23060124_lsu_axil_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 encodings for loads
// and stores, the AXI OKAY response code, the controller state type, and an
// alignment helper used when a request is accepted.
package ysyx_23060124_lsu_axil_pkg;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR   = 3'd3,
        ST_WR_B = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    // funct3[1:0] gives the access size for both loads and stores
    // (00 byte, 01 half, 10 word); the unsigned bit does not matter here.
    function automatic logic is_misaligned(input logic [2:0] opt, input logic [1:0] addr_lo);
        case (opt[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060124_lsu_lane.sv
// Byte-lane steering for a 4-byte data bus (purely combinational).
//   addr_lo   : low two bits of the latched request address
//   opt       : latched funct3
//   st_data   : right-aligned store data
//   bus_wdata : store data replicated across lanes (SB x4, SH x2, SW as-is)
//   bus_wstrb : byte strobes for the addressed lanes
//   bus_rdata : raw read data word from the bus
//   ld_data   : selected lane, sign- or zero-extended to 32 bits
module ysyx_23060124_lsu_lane
    import ysyx_23060124_lsu_axil_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          addr_lo,
    input  logic [2:0]          opt,
    input  logic [DATA_W-1:0]   st_data,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic [DATA_W-1:0]   ld_data
);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  sb;
        logic signed [31:0] wide;
        sb   = b;
        wide = 32'(sb);
        return sgn ? wide : {24'h0, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        logic signed [31:0] wide;
        sh   = h;
        wide = 32'(sh);
        return sgn ? wide : {16'h0, h};
    endfunction

    logic [DATA_W-1:0] shifted;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign shifted = bus_rdata >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = bus_rdata;
        case (opt)
            F3_B:    ld_data = extend_byte(shifted[7:0], 1'b1);
            F3_BU:   ld_data = extend_byte(shifted[7:0], 1'b0);
            F3_H:    ld_data = extend_half(shifted[15:0], 1'b1);
            F3_HU:   ld_data = extend_half(shifted[15:0], 1'b0);
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        bus_wdata = st_data;
        bus_wstrb = 4'b1111;
        case (opt[1:0])
            2'b00: begin
                bus_wdata = {4{st_data[7:0]}};
                bus_wstrb = 4'b0001 << addr_lo;
            end
            2'b01: begin
                bus_wdata = {2{st_data[15:0]}};
                bus_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                bus_wdata = st_data;
                bus_wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060124_lsu_axil.sv
// Load/store unit: turns one EXU load/store request into a single-beat
// AXI4-Lite transaction and reports the result to writeback.
//   clk, i_rst                 : clock, synchronous active-high reset
//   i_req_valid/o_req_ready    : request handshake (ready only when idle)
//   i_load/i_store/i_opt       : request kind and funct3
//   i_addr/i_wdata             : byte address and right-aligned store data
//   o_done/o_rdata/o_err       : one-cycle completion pulse with result;
//                                o_rdata/o_err hold until the next o_done
//   AR/R/AW/W/B channel ports  : AXI4-Lite master side
// One request is outstanding at a time; misaligned requests complete with an
// error without touching the bus.
module ysyx_23060124_lsu_axil
    import ysyx_23060124_lsu_axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_load,
    input  logic                i_store,
    input  logic [2:0]          i_opt,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_err,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rvalid,
    output logic                o_rready,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
);

    lsu_state_e state_q, state_d;

    // Latched request (stage 0) and latched result (stage 1).
    logic [ADDR_W-1:0] addr_p0;
    logic [2:0]        opt_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;

    // AW and W complete independently; these remember which one already has.
    logic aw_done_q, w_done_q;

    logic              accept;
    logic              aw_fin, w_fin;
    logic              res_we;
    logic              res_err_d;
    logic [DATA_W-1:0] res_rdata_d;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W/8-1:0] lane_wstrb;

    ysyx_23060124_lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .addr_lo   (addr_p0[1:0]),
        .opt       (opt_p0),
        .st_data   (wdata_p0),
        .bus_wdata (lane_wdata),
        .bus_wstrb (lane_wstrb),
        .bus_rdata (i_rdata),
        .ld_data   (ld_data)
    );

    // A request with neither load nor store set is not accepted at all.
    assign accept = (state_q == ST_IDLE) && i_req_valid && (i_load || i_store);

    assign aw_fin = aw_done_q || (o_awvalid && i_awready);
    assign w_fin  = w_done_q  || (o_wvalid  && i_wready);

    always_comb begin
        state_d     = state_q;
        res_we      = 1'b0;
        res_err_d   = 1'b0;
        res_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_misaligned(i_opt, i_addr[1:0])) begin
                        state_d   = ST_DONE;
                        res_we    = 1'b1;
                        res_err_d = 1'b1;
                    end else if (i_load) begin
                        state_d = ST_RD_A;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD_A: begin
                if (i_arready) state_d = ST_RD_D;
            end
            ST_RD_D: begin
                if (i_rvalid) begin
                    state_d     = ST_DONE;
                    res_we      = 1'b1;
                    res_err_d   = (i_rresp != RESP_OKAY);
                    res_rdata_d = res_err_d ? '0 : ld_data;
                end
            end
            ST_WR: begin
                if (aw_fin && w_fin) state_d = ST_WR_B;
            end
            ST_WR_B: begin
                if (i_bvalid) begin
                    state_d   = ST_DONE;
                    res_we    = 1'b1;
                    res_err_d = (i_bresp != RESP_OKAY);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_p0   <= '0;
            opt_p0    <= '0;
            wdata_p0  <= '0;
            rdata_p1  <= '0;
            err_p1    <= 1'b0;
        end else begin
            state_q <= state_d;

            // stage 0: request capture
            if (accept) begin
                addr_p0  <= i_addr;
                opt_p0   <= i_opt;
                wdata_p0 <= i_wdata;
            end

            if (state_q == ST_WR) begin
                aw_done_q <= aw_fin;
                w_done_q  <= w_fin;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            // stage 1: result capture, held until the next completion
            if (res_we) begin
                rdata_p1 <= res_rdata_d;
                err_p1   <= res_err_d;
            end
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_rdata     = rdata_p1;
    assign o_err       = err_p1;

    assign o_arvalid = (state_q == ST_RD_A);
    assign o_araddr  = {addr_p0[ADDR_W-1:2], 2'b00};
    assign o_rready  = (state_q == ST_RD_D);

    assign o_awvalid = (state_q == ST_WR) && !aw_done_q;
    assign o_awaddr  = {addr_p0[ADDR_W-1:2], 2'b00};
    assign o_wvalid  = (state_q == ST_WR) && !w_done_q;
    assign o_wdata   = lane_wdata;
    assign o_wstrb   = lane_wstrb;
    assign o_bready  = (state_q == ST_WR_B);

endmodule

// File: tb/tb_ysyx_23060124_lsu_axil.sv
module tb_ysyx_23060124_lsu_axil;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, load, store;
    logic [2:0]  opt;
    logic [31:0] addr, wdata;
    logic        o_req_ready, o_done, o_err;
    logic [31:0] o_rdata, o_araddr, o_awaddr, o_wdata;
    logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
    logic [3:0]  o_wstrb;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    always #5 clk = ~clk;

    ysyx_23060124_lsu_axil dut (
        .clk (clk), .i_rst (rst),
        .i_req_valid (req_valid), .o_req_ready (o_req_ready),
        .i_load (load), .i_store (store), .i_opt (opt),
        .i_addr (addr), .i_wdata (wdata),
        .o_done (o_done), .o_rdata (o_rdata), .o_err (o_err),
        .o_araddr (o_araddr), .o_arvalid (o_arvalid), .i_arready (arready),
        .i_rdata (rdata), .i_rresp (rresp), .i_rvalid (rvalid), .o_rready (o_rready),
        .o_awaddr (o_awaddr), .o_awvalid (o_awvalid), .i_awready (awready),
        .o_wdata (o_wdata), .o_wstrb (o_wstrb), .o_wvalid (o_wvalid), .i_wready (wready),
        .i_bresp (bresp), .i_bvalid (bvalid), .o_bready (o_bready)
    );

    int checks = 0;
    int failures = 0;

    // slave behaviour for the next transaction
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_resp;

    // what the last transaction looked like on the pins
    logic        ob_accept_ready, ob_busy_ready, ob_ready_after, ob_timeout;
    logic        ob_ar_seen, ob_aw_seen, ob_w_seen, ob_ar_drop, ob_aw_extra, ob_w_extra;
    logic [31:0] ob_araddr, ob_awaddr, ob_wdata, ob_rdata, ob_hold_rdata;
    logic [3:0]  ob_wstrb;
    logic        ob_err, ob_hold_err;
    int          ob_done_cnt, ob_done_cyc, ob_aw_hs_cyc, ob_w_hs_cyc;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        longint w, v, span;
        int sz, off;
        sz   = size_of(f3);
        off  = int'(a[1:0]);
        w    = longint'({32'h0, word});
        span = longint'(1) << (8 * sz);
        v    = (w >> (8 * off)) % span;
        if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] e;
        int sz, off;
        sz  = size_of(f3);
        off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) e[i] = (i >= off) && (i < off + sz);
        return e;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] e;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) e[8*i +: 8] = wd[8*(i % sz) +: 8];
        return e;
    endfunction

    // ---------------- transaction driver + slave ----------------
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        bit ar_d, r_d, aw_d, w_d, b_d;
        int arw, rw, aww, ww, bw, cyc;
        ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
        arw = 0; rw = 0; aww = 0; ww = 0; bw = 0;
        ob_busy_ready = 0; ob_ready_after = 0; ob_timeout = 0;
        ob_ar_seen = 0; ob_aw_seen = 0; ob_w_seen = 0;
        ob_ar_drop = 0; ob_aw_extra = 0; ob_w_extra = 0;
        ob_araddr = 0; ob_awaddr = 0; ob_wdata = 0; ob_wstrb = 0;
        ob_rdata = 0; ob_err = 0; ob_hold_rdata = 0; ob_hold_err = 0;
        ob_done_cnt = 0; ob_done_cyc = -1; ob_aw_hs_cyc = -1; ob_w_hs_cyc = -1;

        req_valid = 1; load = ld; store = st; opt = f3; addr = a; wdata = wd;
        ob_accept_ready = o_req_ready;
        @(posedge clk); #1;
        req_valid = 0; load = 0; store = 0;
        cyc = 1;
        forever begin
            arready = o_arvalid && (arw >= ar_dly);
            rvalid  = ar_d && !r_d && (rw >= r_dly);
            awready = o_awvalid && (aww >= aw_dly);
            wready  = o_wvalid && (ww >= w_dly);
            bvalid  = aw_d && w_d && !b_d && (bw >= b_dly);
            rdata = sl_rdata; rresp = sl_resp; bresp = sl_resp;

            if (o_arvalid) begin ob_ar_seen = 1; ob_araddr = o_araddr; arw++; end
            else if (ob_ar_seen && !ar_d) ob_ar_drop = 1;
            if (o_awvalid) begin if (aw_d) ob_aw_extra = 1; ob_aw_seen = 1; ob_awaddr = o_awaddr; aww++; end
            if (o_wvalid) begin if (w_d) ob_w_extra = 1; ob_w_seen = 1; ob_wdata = o_wdata; ob_wstrb = o_wstrb; ww++; end
            if (ar_d && !r_d) rw++;
            if (aw_d && w_d && !b_d) bw++;

            if (o_arvalid && arready) ar_d = 1;
            if (rvalid && o_rready) r_d = 1;
            if (o_awvalid && awready) begin aw_d = 1; ob_aw_hs_cyc = cyc; end
            if (o_wvalid && wready) begin w_d = 1; ob_w_hs_cyc = cyc; end
            if (bvalid && o_bready) b_d = 1;

            if (ob_done_cnt == 0 && o_req_ready) ob_busy_ready = 1;
            if (o_done) begin
                ob_done_cnt++;
                if (ob_done_cnt == 1) begin ob_done_cyc = cyc; ob_rdata = o_rdata; ob_err = o_err; end
            end
            if (ob_done_cyc > 0 && cyc == ob_done_cyc + 1) ob_ready_after = o_req_ready;
            if (ob_done_cyc > 0 && cyc == ob_done_cyc + 3) begin
                ob_hold_rdata = o_rdata; ob_hold_err = o_err;
                break;
            end
            if (cyc >= 150) begin ob_timeout = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    endtask

    task automatic zero_wait();
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; sl_resp = 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1; rst = 0;
        checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_req_ready); end
        checks++; if ({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_done, o_err} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_done, o_err}); end
        checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
    endtask

    task automatic test_load_directed();
        zero_wait();
        sl_rdata = 32'h80AA_BBCC;
        run_txn(1, 0, 3'b000, 32'h8000_0003, 32'h0);
        checks++; if (ob_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", ob_rdata); end
        checks++; if (ob_err !== 1'b0) begin failures++; $display("FAIL lb_err got=%b exp=0", ob_err); end
        checks++; if (ob_araddr !== 32'h8000_0000) begin failures++; $display("FAIL lb_araddr got=%h exp=80000000", ob_araddr); end
        checks++; if (ob_done_cyc != 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", ob_done_cyc); end
        sl_rdata = 32'hF00D_1234;
        run_txn(1, 0, 3'b101, 32'h8000_0002, 32'h0);
        checks++; if (ob_rdata !== 32'h0000_F00D) begin failures++; $display("FAIL lhu_rdata got=%h exp=0000f00d", ob_rdata); end
        checks++; if (ob_done_cnt != 1) begin failures++; $display("FAIL lhu_done_count got=%0d exp=1", ob_done_cnt); end
    endtask

    task automatic test_store_directed();
        zero_wait();
        w_dly = 2;
        run_txn(0, 1, 3'b001, 32'h8000_0002, 32'h0000_1234);
        checks++; if (ob_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", ob_wstrb); end
        checks++; if (ob_wdata !== 32'h1234_1234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", ob_wdata); end
        checks++; if (!(ob_aw_hs_cyc >= 0 && ob_w_hs_cyc == ob_aw_hs_cyc + 2)) begin
            failures++; $display("FAIL sh_hs_order aw=%0d w=%0d exp w=aw+2", ob_aw_hs_cyc, ob_w_hs_cyc); end
        checks++; if ({ob_aw_extra, ob_w_extra} !== 2'b00) begin failures++; $display("FAIL sh_valid_drop got=%b exp=00", {ob_aw_extra, ob_w_extra}); end
        checks++; if (ob_done_cnt != 1 || ob_err !== 1'b0) begin failures++; $display("FAIL sh_done cnt=%0d err=%b exp cnt=1 err=0", ob_done_cnt, ob_err); end
        zero_wait();
        run_txn(0, 1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
        checks++; if (ob_done_cyc != 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", ob_done_cyc); end
        checks++; if (ob_wstrb !== 4'b1111 || ob_wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sw_bus got=%b/%h exp=1111/deadbeef", ob_wstrb, ob_wdata); end
    endtask

    task automatic test_misaligned();
        zero_wait();
        sl_rdata = 32'h1111_1111;
        run_txn(1, 0, 3'b010, 32'h8000_0001, 32'h0);
        checks++; if (ob_ar_seen !== 1'b0) begin failures++; $display("FAIL lw_mis_ar got=%b exp=0", ob_ar_seen); end
        checks++; if (ob_err !== 1'b1 || ob_rdata !== 32'h0) begin failures++; $display("FAIL lw_mis_result err=%b rdata=%h exp err=1 rdata=0", ob_err, ob_rdata); end
        checks++; if (ob_done_cyc < 1 || ob_done_cyc > 2) begin failures++; $display("FAIL lw_mis_latency got=%0d exp<=2", ob_done_cyc); end
        run_txn(0, 1, 3'b001, 32'h8000_0003, 32'h5555);
        checks++; if ({ob_aw_seen, ob_w_seen} !== 2'b00 || ob_err !== 1'b1) begin
            failures++; $display("FAIL sh_mis bus=%b err=%b exp bus=00 err=1", {ob_aw_seen, ob_w_seen}, ob_err); end
    endtask

    task automatic test_store_error();
        zero_wait();
        sl_resp = 2'b10;
        run_txn(0, 1, 3'b010, 32'h0000_2000, 32'h0BAD_F00D);
        checks++; if (ob_err !== 1'b1 || ob_rdata !== 32'h0) begin failures++; $display("FAIL sw_berr err=%b rdata=%h exp err=1 rdata=0", ob_err, ob_rdata); end
        checks++; if (ob_busy_ready !== 1'b0) begin failures++; $display("FAIL sw_busy_ready got=%b exp=0", ob_busy_ready); end
        checks++; if (ob_ready_after !== 1'b1) begin failures++; $display("FAIL sw_ready_after got=%b exp=1", ob_ready_after); end
        checks++; if (ob_hold_err !== 1'b1) begin failures++; $display("FAIL sw_err_hold got=%b exp=1", ob_hold_err); end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        req_valid = 1; load = 1; store = 0; opt = 3'b010; addr = 32'h0000_3000;
        @(posedge clk); #1;
        req_valid = 0; load = 0;
        arready = 1;
        @(posedge clk); #1;
        arready = 0;
        checks++; if (o_rready !== 1'b1) begin failures++; $display("FAIL rstmid_in_rd_d rready=%b exp=1", o_rready); end
        rvalid = 1; rdata = 32'hCAFE_CAFE; rresp = 2'b00; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++; if (o_rready !== 1'b0 || o_req_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_idle rready=%b ready=%b exp rready=0 ready=1", o_rready, o_req_ready); end
        for (int i = 0; i < 4; i++) begin
            if (o_done) seen_done++;
            @(posedge clk); #1;
        end
        rvalid = 0;
        checks++; if (seen_done != 0 || o_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_no_done dones=%0d rdata=%h exp 0/0", seen_done, o_rdata); end
    endtask

    task automatic test_corner_flags();
        int bus_seen;
        bus_seen = 0;
        req_valid = 1; load = 0; store = 0; opt = 3'b010; addr = 32'h0000_4000;
        @(posedge clk); #1;
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_arvalid || o_awvalid || o_done || !o_req_ready) bus_seen++;
            @(posedge clk); #1;
        end
        checks++; if (bus_seen != 0) begin failures++; $display("FAIL neither_ignored activity=%0d exp=0", bus_seen); end
        zero_wait();
        sl_rdata = 32'h1357_9BDF;
        run_txn(1, 1, 3'b010, 32'h0000_4004, 32'hFFFF_FFFF);
        checks++; if ({ob_ar_seen, ob_aw_seen} !== 2'b10 || ob_rdata !== 32'h1357_9BDF) begin
            failures++; $display("FAIL both_as_load bus=%b rdata=%h exp bus=10 rdata=13579bdf", {ob_ar_seen, ob_aw_seen}, ob_rdata); end
    endtask

    task automatic test_back_to_back();
        logic is_ld;
        logic [2:0] f3;
        logic [31:0] a, wd, er;
        logic [2:0] ld_ops [5];
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 8; n++) begin
            zero_wait();
            is_ld = $urandom_range(0, 1) == 1;
            f3 = is_ld ? ld_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a  = $urandom & ~(size_of(f3) - 1);
            wd = $urandom; sl_rdata = $urandom;
            er = is_ld ? exp_load(f3, a, sl_rdata) : 32'h0;
            run_txn(is_ld, !is_ld, f3, a, wd);
            checks++; if (ob_done_cyc != 3 || ob_rdata !== er || ob_accept_ready !== 1'b1) begin
                failures++; $display("FAIL b2b[%0d] lat=%0d rdata=%h ready=%b exp lat=3 rdata=%h ready=1", n, ob_done_cyc, ob_rdata, ob_accept_ready, er); end
        end
    endtask

    task automatic test_random();
        logic is_ld, mis, eerr;
        logic [2:0] f3;
        logic [31:0] a, wd, erd;
        logic [2:0] ld_ops [5];
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 60; n++) begin
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            sl_resp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sl_rdata = $urandom;
            is_ld = $urandom_range(0, 1) == 1;
            f3 = is_ld ? ld_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~(size_of(f3) - 1);
            wd = $urandom;
            mis  = exp_mis(f3, a);
            eerr = mis || (sl_resp != 2'b00);
            erd  = (is_ld && !eerr) ? exp_load(f3, a, sl_rdata) : 32'h0;
            run_txn(is_ld, !is_ld, f3, a, wd);
            checks++; if (ob_timeout !== 1'b0 || ob_done_cnt != 1) begin
                failures++; $display("FAIL rnd[%0d]_done timeout=%b dones=%0d exp 0/1", n, ob_timeout, ob_done_cnt); end
            checks++; if (ob_rdata !== erd || ob_err !== eerr) begin
                failures++; $display("FAIL rnd[%0d]_result op=%b addr=%h rdata=%h err=%b exp rdata=%h err=%b", n, f3, a, ob_rdata, ob_err, erd, eerr); end
            checks++; if ({ob_ar_seen, ob_aw_seen} !== {is_ld && !mis, !is_ld && !mis}) begin
                failures++; $display("FAIL rnd[%0d]_bus got=%b exp=%b", n, {ob_ar_seen, ob_aw_seen}, {is_ld && !mis, !is_ld && !mis}); end
            checks++; if (ob_hold_rdata !== erd || ob_hold_err !== eerr || ob_busy_ready !== 1'b0) begin
                failures++; $display("FAIL rnd[%0d]_hold rdata=%h err=%b busy=%b exp %h/%b/0", n, ob_hold_rdata, ob_hold_err, ob_busy_ready, erd, eerr); end
            if (is_ld && !mis) begin
                checks++; if (ob_araddr !== {a[31:2], 2'b00} || ob_ar_drop !== 1'b0) begin
                    failures++; $display("FAIL rnd[%0d]_ar araddr=%h drop=%b exp %h/0", n, ob_araddr, ob_ar_drop, {a[31:2], 2'b00}); end
            end
            if (!is_ld && !mis) begin
                checks++; if (ob_wstrb !== exp_wstrb(f3, a) || ob_wdata !== exp_wdata(f3, wd)) begin
                    failures++; $display("FAIL rnd[%0d]_w wstrb=%b wdata=%h exp %b/%h", n, ob_wstrb, ob_wdata, exp_wstrb(f3, a), exp_wdata(f3, wd)); end
                checks++; if (ob_awaddr[31:2] !== a[31:2] || {ob_aw_extra, ob_w_extra} !== 2'b00) begin
                    failures++; $display("FAIL rnd[%0d]_aw awaddr=%h extra=%b exp word %h/00", n, ob_awaddr, {ob_aw_extra, ob_w_extra}, a[31:2]); end
            end
        end
    endtask

    initial begin
        rst = 1; req_valid = 0; load = 0; store = 0; opt = 0; addr = 0; wdata = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = 0; rresp = 0; bresp = 0;
        zero_wait(); sl_rdata = 0;
        test_reset();
        test_load_directed();
        test_store_directed();
        test_misaligned();
        test_store_error();
        test_reset_mid();
        test_corner_flags();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
